pci_arbiter_rr: RTL and testbench
=================================

// Module: pci_arbiter_rr
// PURPOSE
//   Parametrised central bus arbiter for the shared PCI-style bus. Generalises the fixed
//   three-device priority arbiter to N_REQ requesters with selectable fixed or round-robin
//   priority. Adds a grant-timeout for masters that never start a frame, and a turnaround
//   cycle between owners. Sits beside the Device instances and drives one active-low
//   grant per device.
// PARAMETERS
//   N_REQ      4   number of requesters (2..16)
//   RR_MODE    1   0 = fixed priority (index 0 highest); 1 = round-robin
//   TIMEOUT    16  cycles a granted master may leave frame high before its grant is revoked (>=2)
//   ID_W       $clog2(N_REQ)  width of gnt_id (derived, not overridden)
// PORTS
//   clk          in   1      bus clock, all logic on posedge
//   reset        in   1      synchronous, active-high
//   req_n        in   N_REQ  per-device request, active-low
//   frame        in   1      shared frame, active-low (1 = no transaction)
//   i_ready      in   1      shared initiator ready, active-low
//   gnt_n        out  N_REQ  per-device grant, active-low, at most one bit low (one-hot-low)
//   gnt_id       out  ID_W   index of the current/last granted device
//   bus_busy     out  1      1 while in GRANT or BUSY
//   timeout_pls  out  1      one-cycle pulse when a grant is revoked by timeout
// BEHAVIOUR
//   Reset (reset=1 at posedge): gnt_n=all 1, gnt_id=0, bus_busy=0, timeout_pls=0, state=IDLE,
//     rr_ptr=N_REQ-1 (so index 0 is first in RR order), tcnt=0. Reset overrides every other event.
//   bus_idle = frame & i_ready (both high).
//   States: IDLE, GRANT, BUSY, TURN. All outputs registered.
//   IDLE: if any req_n low and bus_idle, then select a winner W, drive gnt_n[W]=0 and gnt_id=W
//     at the next edge, set tcnt=0, and go to GRANT. Grant latency is 1 cycle from req sample.
//     Otherwise stay in IDLE with gnt_n all 1.
//   Winner: RR_MODE=0 -> lowest index with req_n low. RR_MODE=1 -> first requesting index
//     after rr_ptr, searching circularly (rr_ptr+1 .. rr_ptr, mod N_REQ).
//   GRANT: the grant is held. Checks are made in this order:
//     a) frame=0 -> BUSY; rr_ptr<=W.
//     b) req_n[W]=1 (request withdrawn) -> release grant -> IDLE; rr_ptr unchanged.
//     c) tcnt==TIMEOUT-1 -> release grant, timeout_pls=1 for 1 cycle, rr_ptr<=W -> IDLE.
//     d) otherwise tcnt++.
//   BUSY: the grant is held regardless of req_n. When bus_idle (frame and i_ready both high,
//     i.e. after the last data phase), release the grant -> TURN.
//   TURN: exactly one cycle with all grants high (bus turnaround), then -> IDLE.
//     So the minimum gap from bus_idle to the next grant is 2 cycles.
//   bus_busy = (state==GRANT || state==BUSY). gnt_id holds its value outside grants.
//   Simultaneous events:
//     - New requests arriving during GRANT/BUSY/TURN are not latched; they are sampled again in IDLE.
//     - frame falling in the same cycle that tcnt expires counts as a start (a wins).
//     - With a single requester in RR mode, it is re-granted every arbitration.
//   Reset mid-transaction drops the grant at that edge; frame is ignored until IDLE.
//   Invariant: popcount(~gnt_n) <= 1 every cycle.
// TESTING
//   1 Reset: hold reset 2 cycles with req_n=0000 -> gnt_n=1111, bus_busy=0, timeout_pls=0.
//   2 Fixed priority (RR_MODE=0): req_n=1010 idle bus -> gnt_n=1110 next cycle; device 0
//     frames 3 cycles and releases -> TURN with 1111 for 1 cycle, then gnt_n=1011 (dev 2).
//   3 Round-robin: req_n=0000 held, each owner runs a 2-cycle frame -> grant order 0,1,2,3,0;
//     gnt_id follows 0,1,2,3,0.
//   4 Timeout: req_n=1101, frame never falls -> gnt_n=1101 for 16 cycles, then 1111 with
//     timeout_pls=1 for 1 cycle; in RR mode the next grant goes to another requester if present.
//   5 Withdraw: dev 3 granted, req_n[3] goes high before frame -> gnt_n=1111 next cycle,
//     timeout_pls=0, rr_ptr unchanged (dev 3 is still first among requesters after the pointer).
//   6 Reset mid-BUSY: reset=1 while frame=0 -> gnt_n=1111 at that edge, state IDLE; a bench
//     assertion checks one-hot-low gnt_n throughout all scenarios.

Source files
------------

// File: rtl/pci_arbiter_rr_if.sv
// Shared-bus arbitration signals: per-device requests and grants plus the
// shared frame / initiator-ready lines the arbiter watches.
interface pci_arbiter_rr_if #(
  parameter int N_REQ = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0] req_n;
  logic             frame;
  logic             i_ready;
  logic [N_REQ-1:0] gnt_n;
  logic [ID_W-1:0]  gnt_id;
  logic             bus_busy;
  logic             timeout_pls;

  // Arbiter side: observes requests and bus activity, drives grants.
  modport master (
    input  req_n,
    input  frame,
    input  i_ready,
    output gnt_n,
    output gnt_id,
    output bus_busy,
    output timeout_pls
  );

  // Device side: drives requests and bus activity, observes grants.
  modport slave (
    output req_n,
    output frame,
    output i_ready,
    input  gnt_n,
    input  gnt_id,
    input  bus_busy,
    input  timeout_pls
  );
endinterface

// File: rtl/pci_arbiter_rr.sv
// Central arbiter for the shared PCI-style bus. Grants one device at a time
// (fixed or round-robin priority), revokes grants that are never used, and
// inserts one turnaround cycle between bus owners.
module pci_arbiter_rr #(
  parameter int N_REQ   = 4,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  pci_arbiter_rr_if.master bus
);
  localparam int ID_W   = $clog2(N_REQ);
  localparam int TCNT_W = $clog2(TIMEOUT);

  localparam logic [N_REQ-1:0]  GNT_NONE  = {N_REQ{1'b1}};
  localparam logic [N_REQ-1:0]  ONE_LSB   = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(N_REQ - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_BUSY  = 2'd2,
    S_TURN  = 2'd3
  } state_t;

  state_t             state_r;
  logic [N_REQ-1:0]   gnt_n_r;
  logic [ID_W-1:0]    gnt_id_r;
  logic               bus_busy_r;
  logic               timeout_pls_r;
  logic [ID_W-1:0]    rr_ptr_r;
  logic [TCNT_W-1:0]  tcnt_r;

  logic               bus_idle_s;
  logic               any_req_s;
  logic [ID_W-1:0]    base_s;
  logic [ID_W-1:0]    idx_s;
  logic [ID_W-1:0]    win_s;

  assign bus_idle_s = bus.frame & bus.i_ready;
  assign any_req_s  = ~(&bus.req_n);
  // Fixed priority is round-robin with the pointer pinned to the last index,
  // which makes index 0 the first candidate.
  assign base_s     = (RR_MODE != 0) ? rr_ptr_r : LAST_ID;

  // Pick the first requester after base_s, scanning circularly; the scan
  // runs farthest-first so the nearest requester overwrites the result.
  always_comb begin
    win_s = {ID_W{1'b0}};
    idx_s = {ID_W{1'b0}};
    for (int k = N_REQ; k >= 1; k--) begin
      idx_s = ID_W'((int'(base_s) + k) % N_REQ);
      win_s = (!bus.req_n[idx_s]) ? idx_s : win_s;
    end
  end

  // Arbitration state machine with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= S_IDLE;
      gnt_n_r       <= GNT_NONE;
      gnt_id_r      <= {ID_W{1'b0}};
      bus_busy_r    <= 1'b0;
      timeout_pls_r <= 1'b0;
      rr_ptr_r      <= LAST_ID;
      tcnt_r        <= {TCNT_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          timeout_pls_r <= 1'b0;
          if (any_req_s && bus_idle_s) begin
            gnt_n_r    <= ~(ONE_LSB << win_s);
            gnt_id_r   <= win_s;
            tcnt_r     <= {TCNT_W{1'b0}};
            bus_busy_r <= 1'b1;
            state_r    <= S_GRANT;
          end else begin
            gnt_n_r    <= GNT_NONE;
            bus_busy_r <= 1'b0;
          end
        end
        S_GRANT: begin
          // Frame start wins over withdrawal and timeout in the same cycle.
          if (!bus.frame) begin
            rr_ptr_r <= gnt_id_r;
            state_r  <= S_BUSY;
          end else if (bus.req_n[gnt_id_r]) begin
            gnt_n_r    <= GNT_NONE;
            bus_busy_r <= 1'b0;
            state_r    <= S_IDLE;
          end else if (tcnt_r == TCNT_LAST) begin
            gnt_n_r       <= GNT_NONE;
            bus_busy_r    <= 1'b0;
            timeout_pls_r <= 1'b1;
            rr_ptr_r      <= gnt_id_r;
            state_r       <= S_IDLE;
          end else begin
            tcnt_r <= tcnt_r + TCNT_W'(1);
          end
        end
        S_BUSY: begin
          // Owner keeps the grant until the last data phase completes.
          if (bus_idle_s) begin
            gnt_n_r    <= GNT_NONE;
            bus_busy_r <= 1'b0;
            state_r    <= S_TURN;
          end else begin
            state_r <= S_BUSY;
          end
        end
        S_TURN: begin
          gnt_n_r       <= GNT_NONE;
          bus_busy_r    <= 1'b0;
          timeout_pls_r <= 1'b0;
          state_r       <= S_IDLE;
        end
        default: begin
          gnt_n_r       <= GNT_NONE;
          bus_busy_r    <= 1'b0;
          timeout_pls_r <= 1'b0;
          state_r       <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt_n       = gnt_n_r;
  assign bus.gnt_id      = gnt_id_r;
  assign bus.bus_busy    = bus_busy_r;
  assign bus.timeout_pls = timeout_pls_r;
endmodule

// File: tb/tb_pci_arbiter_rr.sv
// Directed bench for pci_arbiter_rr: one fixed-priority and one round-robin
// instance, each with its own bus interface and a shared clock/reset.
module tb_pci_arbiter_rr;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic mon_en;

  pci_arbiter_rr_if #(.N_REQ(4)) bus_fp ();
  pci_arbiter_rr_if #(.N_REQ(4)) bus_rr ();

  pci_arbiter_rr #(.N_REQ(4), .RR_MODE(0), .TIMEOUT(16)) dut_fp (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_fp.master)
  );

  pci_arbiter_rr #(.N_REQ(4), .RR_MODE(1), .TIMEOUT(16)) dut_rr (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_rr.master)
  );

  // Free-running bus clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // At most one grant may be active on either bus in any cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (!$onehot0(~bus_fp.gnt_n)) begin
        errors++;
        $display("FAIL onehot_fp gnt_n=%b required at most one low bit", bus_fp.gnt_n);
      end
      checks++;
      if (!$onehot0(~bus_rr.gnt_n)) begin
        errors++;
        $display("FAIL onehot_rr gnt_n=%b required at most one low bit", bus_rr.gnt_n);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_fp.req_n = 4'b0000;
    bus_rr.req_n = 4'b0000;
    tick();
    tick();
    checks++;
    if (bus_rr.gnt_n !== 4'b1111) begin
      errors++; $display("FAIL reset_gnt gnt_n=%b required 1111", bus_rr.gnt_n);
    end
    checks++;
    if (bus_fp.gnt_n !== 4'b1111) begin
      errors++; $display("FAIL reset_gnt_fp gnt_n=%b required 1111", bus_fp.gnt_n);
    end
    checks++;
    if (bus_rr.bus_busy !== 1'b0 || bus_rr.timeout_pls !== 1'b0 || bus_rr.gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_flags busy=%b tpls=%b id=%0d required 0 0 0",
               bus_rr.bus_busy, bus_rr.timeout_pls, bus_rr.gnt_id);
    end
    bus_fp.req_n = 4'b1111;
    bus_rr.req_n = 4'b1111;
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt [5];
    logic [1:0] exp_id  [5];
    exp_gnt = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    bus_rr.req_n = 4'b0000;
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus_rr.gnt_n !== exp_gnt[k] || bus_rr.gnt_id !== exp_id[k] || bus_rr.bus_busy !== 1'b1) begin
        errors++;
        $display("FAIL rr_grant_%0d gnt_n=%b id=%0d busy=%b required %b %0d 1",
                 k, bus_rr.gnt_n, bus_rr.gnt_id, bus_rr.bus_busy, exp_gnt[k], exp_id[k]);
      end
      if (k < 4) begin
        bus_rr.frame = 1'b0;
        tick();
        checks++;
        if (bus_rr.gnt_n !== exp_gnt[k] || bus_rr.bus_busy !== 1'b1) begin
          errors++;
          $display("FAIL rr_busy_%0d gnt_n=%b busy=%b required %b 1",
                   k, bus_rr.gnt_n, bus_rr.bus_busy, exp_gnt[k]);
        end
        tick();
        bus_rr.frame = 1'b1;
        tick();
        checks++;
        if (bus_rr.gnt_n !== 4'b1111 || bus_rr.bus_busy !== 1'b0) begin
          errors++;
          $display("FAIL rr_turn_%0d gnt_n=%b busy=%b required 1111 0",
                   k, bus_rr.gnt_n, bus_rr.bus_busy);
        end
        tick();
        tick();
      end
    end
    bus_rr.req_n = 4'b1111;
    tick();
    checks++;
    if (bus_rr.gnt_n !== 4'b1111) begin
      errors++; $display("FAIL rr_drop gnt_n=%b required 1111", bus_rr.gnt_n);
    end
  endtask

  task automatic test_timeout_withdraw();
    bus_rr.req_n = 4'b1101;
    tick();
    checks++;
    if (bus_rr.gnt_id !== 2'd1) begin
      errors++; $display("FAIL to_id gnt_id=%0d required 1", bus_rr.gnt_id);
    end
    for (int c = 0; c < 16; c++) begin
      checks++;
      if (bus_rr.gnt_n !== 4'b1101 || bus_rr.timeout_pls !== 1'b0) begin
        errors++;
        $display("FAIL to_hold_%0d gnt_n=%b tpls=%b required 1101 0",
                 c, bus_rr.gnt_n, bus_rr.timeout_pls);
      end
      tick();
    end
    checks++;
    if (bus_rr.gnt_n !== 4'b1111 || bus_rr.timeout_pls !== 1'b1 || bus_rr.bus_busy !== 1'b0) begin
      errors++;
      $display("FAIL to_revoke gnt_n=%b tpls=%b busy=%b required 1111 1 0",
               bus_rr.gnt_n, bus_rr.timeout_pls, bus_rr.bus_busy);
    end
    bus_rr.req_n = 4'b0101;
    tick();
    checks++;
    if (bus_rr.gnt_n !== 4'b0111 || bus_rr.gnt_id !== 2'd3 || bus_rr.timeout_pls !== 1'b0) begin
      errors++;
      $display("FAIL to_next gnt_n=%b id=%0d tpls=%b required 0111 3 0",
               bus_rr.gnt_n, bus_rr.gnt_id, bus_rr.timeout_pls);
    end
    // Device 3 withdraws before starting a frame.
    bus_rr.req_n = 4'b1101;
    tick();
    checks++;
    if (bus_rr.gnt_n !== 4'b1111 || bus_rr.timeout_pls !== 1'b0 || bus_rr.bus_busy !== 1'b0) begin
      errors++;
      $display("FAIL wd_release gnt_n=%b tpls=%b busy=%b required 1111 0 0",
               bus_rr.gnt_n, bus_rr.timeout_pls, bus_rr.bus_busy);
    end
    bus_rr.req_n = 4'b0101;
    tick();
    checks++;
    if (bus_rr.gnt_n !== 4'b0111 || bus_rr.gnt_id !== 2'd3) begin
      errors++;
      $display("FAIL wd_ptr gnt_n=%b id=%0d required 0111 3", bus_rr.gnt_n, bus_rr.gnt_id);
    end
    bus_rr.req_n = 4'b1111;
    tick();
  endtask

  task automatic test_fixed();
    bus_fp.req_n = 4'b1010;
    bus_fp.frame = 1'b0;
    tick();
    checks++;
    if (bus_fp.gnt_n !== 4'b1111) begin
      errors++; $display("FAIL fp_bus_not_idle gnt_n=%b required 1111", bus_fp.gnt_n);
    end
    bus_fp.frame = 1'b1;
    tick();
    checks++;
    if (bus_fp.gnt_n !== 4'b1110 || bus_fp.gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL fp_grant0 gnt_n=%b id=%0d required 1110 0", bus_fp.gnt_n, bus_fp.gnt_id);
    end
    bus_fp.frame = 1'b0;
    tick();
    tick();
    tick();
    bus_fp.frame   = 1'b1;
    bus_fp.i_ready = 1'b0;
    tick();
    checks++;
    if (bus_fp.gnt_n !== 4'b1110 || bus_fp.bus_busy !== 1'b1) begin
      errors++;
      $display("FAIL fp_last_phase gnt_n=%b busy=%b required 1110 1", bus_fp.gnt_n, bus_fp.bus_busy);
    end
    bus_fp.i_ready = 1'b1;
    bus_fp.req_n   = 4'b1011;
    tick();
    checks++;
    if (bus_fp.gnt_n !== 4'b1111 || bus_fp.bus_busy !== 1'b0) begin
      errors++;
      $display("FAIL fp_turn gnt_n=%b busy=%b required 1111 0", bus_fp.gnt_n, bus_fp.bus_busy);
    end
    tick();
    checks++;
    if (bus_fp.gnt_n !== 4'b1111) begin
      errors++; $display("FAIL fp_gap gnt_n=%b required 1111", bus_fp.gnt_n);
    end
    tick();
    checks++;
    if (bus_fp.gnt_n !== 4'b1011 || bus_fp.gnt_id !== 2'd2) begin
      errors++;
      $display("FAIL fp_grant2 gnt_n=%b id=%0d required 1011 2", bus_fp.gnt_n, bus_fp.gnt_id);
    end
    bus_fp.req_n = 4'b1111;
    tick();
  endtask

  task automatic test_reset_busy();
    bus_rr.req_n = 4'b1110;
    tick();
    bus_rr.frame = 1'b0;
    tick();
    checks++;
    if (bus_rr.gnt_n !== 4'b1110 || bus_rr.bus_busy !== 1'b1) begin
      errors++;
      $display("FAIL rb_busy gnt_n=%b busy=%b required 1110 1", bus_rr.gnt_n, bus_rr.bus_busy);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (bus_rr.gnt_n !== 4'b1111 || bus_rr.bus_busy !== 1'b0 || bus_rr.gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL rb_drop gnt_n=%b busy=%b id=%0d required 1111 0 0",
               bus_rr.gnt_n, bus_rr.bus_busy, bus_rr.gnt_id);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus_rr.gnt_n !== 4'b1111) begin
      errors++; $display("FAIL rb_frame_ignored gnt_n=%b required 1111", bus_rr.gnt_n);
    end
    bus_rr.frame = 1'b1;
    tick();
    checks++;
    if (bus_rr.gnt_n !== 4'b1110 || bus_rr.gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL rb_regrant gnt_n=%b id=%0d required 1110 0", bus_rr.gnt_n, bus_rr.gnt_id);
    end
    bus_rr.req_n = 4'b1111;
    tick();
  endtask

  // Scenario sequence.
  initial begin
    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    reset  = 1'b1;
    bus_fp.req_n = 4'b1111; bus_fp.frame = 1'b1; bus_fp.i_ready = 1'b1;
    bus_rr.req_n = 4'b1111; bus_rr.frame = 1'b1; bus_rr.i_ready = 1'b1;
    test_reset();
    test_round_robin();
    test_timeout_withdraw();
    test_fixed();
    test_reset_busy();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
